// File: rtl/kyber_pkg.sv
// kyber_pkg: shared constants and helpers for the Kyber byte-encode datapath.
//   KYBER_N     coefficients per polynomial
//   LEGAL_D     encode widths accepted by ByteEncode_d
//   is_legal_d  returns 1 when d is one of LEGAL_D
//   enc_state_e encode_stream control states
package kyber_pkg;

   localparam int unsigned KYBER_N   = 256;
   localparam int unsigned N_LEGAL_D = 6;

   localparam logic [3:0] LEGAL_D [N_LEGAL_D] = '{4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12};

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } enc_state_e;

   function automatic logic is_legal_d(input logic [3:0] d);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < int'(N_LEGAL_D); i++) begin
         if (d == LEGAL_D[i]) ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/bitpack_acc.sv
// bitpack_acc: LSB-first bit accumulator. Appended bits land directly above the
// bits already held; a pop removes the lowest OUT_W bits. Pop and append may occur
// in the same cycle (pop is applied first, then the append lands above the rest).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   app_valid   append app_len low bits of app_bits this cycle
//   app_bits    bits to append, LSB first
//   app_len     number of valid bits in app_bits
//   pop         drop the lowest OUT_W bits (caller guarantees count >= OUT_W)
//   window      lowest OUT_W bits of the accumulator
//   count       number of valid bits held
module bitpack_acc #(
   parameter int unsigned IN_W  = 24,
   parameter int unsigned OUT_W = 64,
   parameter int unsigned ACC_W = OUT_W + IN_W,
   localparam int unsigned LEN_W = $clog2(IN_W + 1),
   localparam int unsigned CNT_W = $clog2(ACC_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             app_valid,
   input  logic [IN_W-1:0]  app_bits,
   input  logic [LEN_W-1:0] app_len,
   input  logic             pop,
   output logic [OUT_W-1:0] window,
   output logic [CNT_W-1:0] count
);

   logic [ACC_W-1:0] acc_q, acc_d, base_acc;
   logic [CNT_W-1:0] count_q, count_d, base_cnt;
   logic [IN_W-1:0]  app_mask;

   always_comb begin
      base_acc = pop ? (acc_q >> OUT_W) : acc_q;
      base_cnt = pop ? (count_q - CNT_W'(OUT_W)) : count_q;
      // Keep bits above app_len out of the accumulator.
      app_mask = {IN_W{1'b1}} >> (IN_W - 32'(app_len));
      acc_d    = base_acc;
      count_d  = base_cnt;
      if (app_valid) begin
         acc_d   = base_acc | (ACC_W'(app_bits & app_mask) << base_cnt);
         count_d = base_cnt + CNT_W'(app_len);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

   assign window = acc_q[OUT_W-1:0];
   assign count  = count_q;

endmodule

// File: rtl/encode_stream.sv
// encode_stream: streams one 256-coefficient polynomial through ByteEncode_d,
// P_NCOEF coefficients in per beat, P_OBYTES bytes out per beat.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_start, i_l     start a polynomial with encode width d (sampled in IDLE only)
//   i_coeffs         P_NCOEF 12-bit coefficients, coefficient m at [12m+11:12m]
//   i_coeffs_valid / o_coeffs_ready   input beat handshake
//   o_obytes         P_OBYTES bytes, byte k at [8k+7:8k]
//   o_obytes_valid / i_obytes_ready   output beat handshake
//   o_done           one-cycle pulse after the final output beat
//   o_err            one-cycle pulse after an i_start with an illegal d
module encode_stream
   import kyber_pkg::*;
#(
   parameter int unsigned P_NCOEF  = 2,
   parameter int unsigned P_OBYTES = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [3:0]              i_l,
   input  logic [12*P_NCOEF-1:0]   i_coeffs,
   input  logic                    i_coeffs_valid,
   output logic                    o_coeffs_ready,
   output logic [8*P_OBYTES-1:0]   o_obytes,
   output logic                    o_obytes_valid,
   input  logic                    i_obytes_ready,
   output logic                    o_done,
   output logic                    o_err
);

   localparam int unsigned IN_W    = 12 * P_NCOEF;
   localparam int unsigned OUT_W   = 8 * P_OBYTES;
   localparam int unsigned ACC_W   = OUT_W + IN_W;
   localparam int unsigned LEN_W   = $clog2(IN_W + 1);
   localparam int unsigned CNT_W   = $clog2(ACC_W + 1);
   localparam int unsigned N_BEATS = KYBER_N / P_NCOEF;
   localparam int unsigned BEAT_W  = $clog2(N_BEATS + 1);
   localparam int unsigned OBEAT_W = $clog2(32 * 12 + 1);

   enc_state_e         state_q, state_d;
   logic [3:0]         dlen_q, dlen_d;
   logic [BEAT_W-1:0]  in_cnt_q, in_cnt_d;
   logic [OBEAT_W-1:0] out_cnt_q, out_cnt_d, out_total;
   logic               done_q, done_d, err_q, err_d;
   logic [IN_W-1:0]    packed_bits;
   logic [11:0]        coef_mask;
   logic [LEN_W-1:0]   app_len;
   logic [CNT_W-1:0]   count;
   logic               accept, pop;

   // Compact the low d bits of each coefficient into a contiguous LSB-first field.
   always_comb begin
      coef_mask   = 12'hFFF >> (32'd12 - 32'(dlen_q));
      packed_bits = '0;
      for (int m = 0; m < int'(P_NCOEF); m++) begin
         packed_bits = packed_bits
                     | (IN_W'(i_coeffs[12*m +: 12] & coef_mask) << (32'(m) * 32'(dlen_q)));
      end
   end

   assign app_len        = LEN_W'(32'(dlen_q) * P_NCOEF);
   assign o_coeffs_ready = (state_q == StRun) && (32'(in_cnt_q) != N_BEATS)
                           && (32'(count) + 32'(app_len) <= ACC_W);
   assign o_obytes_valid = (32'(count) >= OUT_W);
   assign accept         = o_coeffs_ready & i_coeffs_valid;
   assign pop            = o_obytes_valid & i_obytes_ready;
   assign out_total      = OBEAT_W'((32'd32 * 32'(dlen_q)) / P_OBYTES);

   bitpack_acc #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .ACC_W (ACC_W)
   ) u_acc (
      .clk       (i_clk),
      .rst       (i_rst),
      .app_valid (accept),
      .app_bits  (packed_bits),
      .app_len   (app_len),
      .pop       (pop),
      .window    (o_obytes),
      .count     (count)
   );

   always_comb begin
      state_d   = state_q;
      dlen_d    = dlen_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               if (is_legal_d(i_l)) begin
                  state_d   = StRun;
                  dlen_d    = i_l;
                  in_cnt_d  = '0;
                  out_cnt_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (accept) begin
               in_cnt_d = in_cnt_q + 1'b1;
               if (32'(in_cnt_q) == N_BEATS - 1) state_d = StDrain;
            end
            if (pop) out_cnt_d = out_cnt_q + 1'b1;
         end
         StDrain: begin
            if (pop) begin
               out_cnt_d = out_cnt_q + 1'b1;
               // All input is in, so the last output beat empties the accumulator.
               if (out_cnt_q == out_total - 1'b1) begin
                  state_d   = StIdle;
                  done_d    = 1'b1;
                  out_cnt_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         dlen_q    <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dlen_q    <= dlen_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign o_done = done_q;
   assign o_err  = err_q;

endmodule

// File: tb/tb_encode_stream.sv
// tb_encode_stream: randomized-handshake bench for encode_stream (default parameters)
// against a bit-stream model of ByteEncode_d.
module tb_encode_stream;

   localparam int NC = 2;
   localparam int OB = 8;
   localparam int BUDGET = 4000;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [3:0]  i_l = '0;
   logic [23:0] i_coeffs = '0;
   logic        i_coeffs_valid = 1'b0;
   logic        i_obytes_ready = 1'b0;
   logic        o_coeffs_ready;
   logic [63:0] o_obytes;
   logic        o_obytes_valid;
   logic        o_done;
   logic        o_err;

   int total = 0;
   int bad = 0;

   logic [11:0] coef [256];
   logic [7:0]  exp_bytes [384];
   int          done_cnt;
   logic [63:0] first_beat;
   logic        ready_fell;

   always #5 i_clk = ~i_clk;

   encode_stream #(
      .P_NCOEF  (NC),
      .P_OBYTES (OB)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_start        (i_start),
      .i_l            (i_l),
      .i_coeffs       (i_coeffs),
      .i_coeffs_valid (i_coeffs_valid),
      .o_coeffs_ready (o_coeffs_ready),
      .o_obytes       (o_obytes),
      .o_obytes_valid (o_obytes_valid),
      .i_obytes_ready (i_obytes_ready),
      .o_done         (o_done),
      .o_err          (o_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ByteEncode_d: coefficient i bit b -> stream bit i*d+b -> byte (i*d+b)/8.
   task automatic build_model(input int d);
      int p;
      for (int k = 0; k < 384; k++) exp_bytes[k] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         for (int b = 0; b < d; b++) begin
            p = i * d + b;
            exp_bytes[p / 8][p % 8] = coef[i][b];
         end
      end
   endtask

   function automatic logic [63:0] exp_beat(input int k);
      logic [63:0] r;
      for (int j = 0; j < OB; j++) r[8*j +: 8] = exp_bytes[OB*k + j];
      return r;
   endfunction

   task automatic fill_coefs(input int mode);
      for (int i = 0; i < 256; i++) begin
         case (mode)
            0:       coef[i] = (i % 2 == 0) ? 12'd1 : 12'd0;
            1:       coef[i] = 12'hABC;
            2:       coef[i] = 12'($urandom);
            3:       coef[i] = 12'hFFF;
            default: coef[i] = 12'(i % 16);
         endcase
      end
   endtask

   // Entered and left on a falling edge. Returns one cycle after the final beat
   // (the o_done cycle) or right after abort_at input beats when abort_at > 0.
   task automatic run_poly(input int d, input int mode, input int stall_at, input int abort_at);
      int nb, nbeats, bin, bout, bits_in, bits_out, cyc, stall_left;
      nb = 256 / NC;
      nbeats = 32 * d / OB;
      bin = 0; bout = 0; bits_in = 0; bits_out = 0; cyc = 0; stall_left = 0;
      fill_coefs(mode);
      build_model(d);
      done_cnt = 0;
      ready_fell = 1'b0;
      first_beat = '0;
      i_start = 1'b1;
      i_l = 4'(d);
      @(negedge i_clk);
      i_start = 1'b0;
      i_l = 4'($urandom);
      while (cyc < BUDGET) begin
         chk("coeffs_ready", o_coeffs_ready,
             (bin < nb) && (bits_in - bits_out + d * NC <= 8 * OB + 12 * NC));
         chk("obytes_valid", o_obytes_valid, (bits_in - bits_out >= 8 * OB));
         if (o_obytes_valid) chk("obytes_data", o_obytes, exp_beat(bout));
         if (o_done) done_cnt++;
         if (bout == nbeats) break;
         if (abort_at > 0 && bin >= abort_at) break;
         i_coeffs_valid = (bin < nb) && ($urandom_range(3) != 0);
         for (int m = 0; m < NC; m++) begin
            i_coeffs[12*m +: 12] = (bin < nb) ? coef[bin*NC + m] : 12'($urandom);
         end
         if (cyc == stall_at) stall_left = 20;
         if (stall_left > 0) begin
            i_obytes_ready = 1'b0;
            if (bin < nb && !o_coeffs_ready) ready_fell = 1'b1;
            stall_left--;
         end else begin
            i_obytes_ready = ($urandom_range(3) != 0);
         end
         if (o_coeffs_ready && i_coeffs_valid) begin
            bin++;
            bits_in += d * NC;
         end
         if (o_obytes_valid && i_obytes_ready) begin
            if (bout == 0) first_beat = o_obytes;
            bout++;
            bits_out += 8 * OB;
         end
         @(negedge i_clk);
         cyc++;
      end
      if (abort_at == 0) chk("beat_count", bout, nbeats);
      i_coeffs_valid = 1'b0;
      i_obytes_ready = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_obytes"}, o_obytes, 64'h0);
      chk({tag, "_valid"}, o_obytes_valid, 1'b0);
      chk({tag, "_ready"}, o_coeffs_ready, 1'b0);
      chk({tag, "_done"}, o_done, 1'b0);
      chk({tag, "_err"}, o_err, 1'b0);
   endtask

   initial begin
      repeat (2) @(negedge i_clk);
      chk_all_zero("reset");
      i_rst = 1'b0;
      @(negedge i_clk);

      // d=1, alternating 1,0 -> 0x55 bytes
      run_poly(1, 0, -1, 0);
      chk("d1_done", done_cnt, 1);
      chk("d1_first", first_beat, 64'h5555_5555_5555_5555);

      // d=12 started in the o_done cycle of the previous polynomial
      run_poly(12, 1, -1, 0);
      chk("d12_done", done_cnt, 1);
      chk("d12_first", first_beat, 64'hCABC_ABCA_BCAB_CABC);

      // d=10 random with a 20-cycle output stall mid-stream
      run_poly(10, 2, 30, 0);
      chk("d10_done", done_cnt, 1);
      chk("d10_ready_fell", ready_fell, 1'b1);

      // illegal d
      @(negedge i_clk);
      i_start = 1'b1;
      i_l = 4'd7;
      @(negedge i_clk);
      i_start = 1'b0;
      i_l = 4'd0;
      chk("err_pulse", o_err, 1'b1);
      chk("err_ready", o_coeffs_ready, 1'b0);
      @(negedge i_clk);
      chk("err_clear", o_err, 1'b0);
      chk("err_idle_ready", o_coeffs_ready, 1'b0);
      chk("err_idle_valid", o_obytes_valid, 1'b0);

      // d=11, all ones
      run_poly(11, 3, -1, 0);
      chk("d11_done", done_cnt, 1);
      chk("d11_first", first_beat, 64'hFFFF_FFFF_FFFF_FFFF);

      // reset after 50 input beats, then d=4 ramp
      @(negedge i_clk);
      run_poly(10, 2, -1, 50);
      chk("abort_no_done", done_cnt, 0);
      i_rst = 1'b1;
      #1;
      chk_all_zero("midrst");
      @(negedge i_clk);
      chk_all_zero("midrst_hold");
      i_rst = 1'b0;
      @(negedge i_clk);
      chk_all_zero("post_rst");
      run_poly(4, 4, -1, 0);
      chk("d4_done", done_cnt, 1);
      chk("d4_first", first_beat, 64'hFEDC_BA98_7654_3210);
      @(negedge i_clk);
      chk("d4_done_single", o_done, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
